user_mgr_arbiter: RTL and testbench

Parametrised N-to-1 OBI manager arbiter for the user domain. It merges `NumMgr` accelerator manager ports onto the single `user_mgr_obi_req_o`/`user_mgr_obi_rsp_i` port toward the Croc crossbar. Arbitration is round-robin and holds the address phase stable until granted. A response-routing FIFO tracks up to `NumMaxTrans` outstanding transactions per the OBI in-order rule. It replaces the direct single-manager assignment, so multiple user accelerators can share the crossbar.

---
 rtl/user_mgr_arbiter_pkg.sv | 39 +++
 rtl/user_mgr_idx_fifo.sv | 49 ++++
 rtl/user_mgr_arbiter.sv | 86 ++++++++
 tb/tb_user_mgr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_mgr_arbiter_pkg.sv
// user_mgr_arbiter_pkg: user-domain manager sizing, OBI manager structs and index helpers
package user_mgr_arbiter_pkg;

    localparam int unsigned NumUserMgr      = 2;
    localparam int unsigned UserMgrMaxTrans = 4;
    localparam int unsigned AidWidth        = 1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(NumUserMgr)-1:0] user_mgr_idx_t;

    typedef struct packed {
        logic [31:0]         addr;
        logic                we;
        logic [3:0]          be;
        logic [31:0]         wdata;
        logic [AidWidth-1:0] aid;
    } mgr_obi_a_t;

    typedef struct packed {
        logic       req;
        mgr_obi_a_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0]         rdata;
        logic [AidWidth-1:0] rid;
        logic                err;
    } mgr_obi_r_t;

    typedef struct packed {
        logic       gnt;
        logic       rvalid;
        mgr_obi_r_t r;
    } mgr_obi_rsp_t;

endpackage

// File: rtl/user_mgr_idx_fifo.sv
// user_mgr_idx_fifo: circular FIFO of granted manager indices, used to route
// in-order OBI responses back to their issuer.
module user_mgr_idx_fifo import user_mgr_arbiter_pkg::*; #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] data,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = idx_width(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = count == CntW'(Depth);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= data;

endmodule

// File: rtl/user_mgr_arbiter.sv
// user_mgr_arbiter: round-robin N-to-1 OBI manager arbiter with address-phase
// lock and an index FIFO steering in-order responses back to their issuer.
module user_mgr_arbiter import user_mgr_arbiter_pkg::*; #(
    parameter int unsigned NumMgr      = NumUserMgr,
    parameter int unsigned NumMaxTrans = UserMgrMaxTrans,
    parameter type         obi_req_t   = mgr_obi_req_t,
    parameter type         obi_rsp_t   = mgr_obi_rsp_t,
    localparam int unsigned IdxW = idx_width(NumMgr),
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  obi_req_t        mgr_req_i [NumMgr],
    output obi_rsp_t        mgr_rsp_o [NumMgr],
    output obi_req_t        req_o,
    input  obi_rsp_t        rsp_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            err_unexp_rsp_o
);

    logic [IdxW-1:0] rr_q, lock_idx_q, scan, sel, head;
    logic            lock_q, full, empty, handshake;

    function automatic logic [IdxW-1:0] wrap(input int unsigned v);
        return IdxW'(v % NumMgr);
    endfunction

    // Descending scan so the requester closest to rr_q wins.
    always_comb begin
        scan = rr_q;
        for (int k = NumMgr - 1; k >= 0; k--)
            if (mgr_req_i[wrap(int'(rr_q) + k)].req) scan = wrap(int'(rr_q) + k);
    end

    assign sel = (lock_q && mgr_req_i[lock_idx_q].req) ? lock_idx_q : scan;

    // Full is registered, so rvalid never reaches req_o.req combinationally.
    always_comb begin
        req_o     = mgr_req_i[sel];
        req_o.req = mgr_req_i[sel].req & ~full & ~rst_i;
    end

    assign handshake = req_o.req & rsp_i.gnt;

    always_comb
        for (int i = 0; i < NumMgr; i++) begin
            mgr_rsp_o[i]        = rsp_i;
            mgr_rsp_o[i].gnt    = handshake && sel == IdxW'(i);
            mgr_rsp_o[i].rvalid = rsp_i.rvalid && !empty && head == IdxW'(i);
        end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            rr_q            <= '0;
            lock_q          <= 1'b0;
            lock_idx_q      <= '0;
            err_unexp_rsp_o <= 1'b0;
        end else begin
            if (rsp_i.rvalid && empty) err_unexp_rsp_o <= 1'b1;
            if (handshake) begin
                rr_q   <= wrap(int'(sel) + 1);
                lock_q <= 1'b0;
            end else if (req_o.req) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end else if (lock_q && !mgr_req_i[lock_idx_q].req) begin
                lock_q <= 1'b0;
            end
        end

    user_mgr_idx_fifo #(
        .Depth(NumMaxTrans),
        .Width(IdxW)
    ) i_fifo (
        .clk  (clk_i),
        .rst  (rst_i),
        .push (handshake),
        .pop  (rsp_i.rvalid),
        .data (sel),
        .head (head),
        .full (full),
        .empty(empty),
        .count(outstanding_o)
    );

endmodule

// File: tb/tb_user_mgr_arbiter.sv
// tb_user_mgr_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the arbiter.
module tb_user_mgr_arbiter;
    import user_mgr_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    mgr_obi_req_t mreq [3];
    mgr_obi_rsp_t mrsp [3];
    mgr_obi_req_t oreq;
    mgr_obi_rsp_t rsp;
    logic [2:0]   outst;
    logic         err;

    int pass_cnt = 0, total_cnt = 0;
    int q[$];
    int glog[$], rlog[$];
    int rr = 0, lidx = 0, s;
    bit lock = 0, merr = 0, any, ereq;
    logic [2:0] eg, ev, ag, av;

    always #5 clk = ~clk;

    user_mgr_arbiter #(.NumMgr(3), .NumMaxTrans(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mgr_req_i      (mreq),
        .mgr_rsp_o      (mrsp),
        .req_o          (oreq),
        .rsp_i          (rsp),
        .outstanding_o  (outst),
        .err_unexp_rsp_o(err)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    endtask

    // Model: outstanding transactions are a queue of issuer ports, in order.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            rr = 0;
            lock = 0;
            merr = 0;
        end
        any = 0;
        s = 0;
        if (lock && mreq[lidx].req) begin
            s = lidx;
            any = 1;
        end else begin
            lock = 0;
            for (int k = 0; k < 3; k++)
                if (!any && mreq[(rr + k) % 3].req) begin
                    s = (rr + k) % 3;
                    any = 1;
                end
        end
        ereq = any && q.size() < 4 && !rst;
        eg = (ereq && rsp.gnt) ? 3'(1 << s) : 3'b0;
        ev = (rsp.rvalid && q.size() > 0) ? 3'(1 << q[0]) : 3'b0;
        for (int i = 0; i < 3; i++) begin
            ag[i] = mrsp[i].gnt;
            av[i] = mrsp[i].rvalid;
            if (ag[i]) glog.push_back(i);
            if (av[i]) rlog.push_back(i);
        end
        chk("req", oreq.req, ereq);
        if (ereq) chk("addr", oreq.a.addr, mreq[s].a.addr);
        chk("gnt", ag, eg);
        chk("rvalid", av, ev);
        if (rsp.rvalid) chk("rdata", mrsp[1].r.rdata, rsp.r.rdata);
        chk("outstanding", outst, q.size());
        chk("err", err, merr);
        if (!rst) begin
            if (rsp.rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1;
            end
            if (ereq && rsp.gnt) begin
                q.push_back(s);
                rr = (s + 1) % 3;
                lock = 0;
            end else if (ereq) begin
                lock = 1;
                lidx = s;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input bit a, input bit b, input bit c);
        mreq[0].req = a;
        mreq[1].req = b;
        mreq[2].req = c;
    endtask

    task automatic do_reset();
        setreq(0, 0, 0);
        rsp = '0;
        rst = 1;
        step();
        rst = 0;
        glog.delete();
        rlog.delete();
    endtask

    initial begin
        rst = 1;
        rsp = '0;
        for (int i = 0; i < 3; i++) begin
            mreq[i] = '0;
            mreq[i].a.addr = 32'h1000_0000 + 32'(i) * 32'h100;
        end
        step();
        step();
        rst = 0;
        @(negedge clk);
        chk("reset_outstanding", outst, 0);
        chk("reset_err", err, 0);
        chk("reset_req", oreq.req, 0);
        step();

        // Round-robin with back-to-back grants, responses one cycle later
        do_reset();
        setreq(1, 1, 1);
        rsp.gnt = 1;
        step();
        rsp.rvalid = 1;
        repeat (5) begin
            rsp.r.rdata = $urandom;
            step();
        end
        setreq(0, 0, 0);
        rsp.gnt = 0;
        step();
        rsp.rvalid = 0;
        chk("rr_len", glog.size(), 6);
        chk("rsp_len", rlog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("rr_order", glog.size() > i ? glog[i] : 99, i % 3);
            chk("rsp_order", rlog.size() > i ? rlog[i] : 99, i % 3);
        end

        // Address-phase lock on mgr1 while mgr0 also requests
        do_reset();
        setreq(1, 0, 0);
        rsp.gnt = 1;
        step();
        rsp.gnt = 0;
        rsp.rvalid = 1;
        setreq(1, 1, 0);
        mreq[1].a.addr = 32'h2000_0010;
        repeat (3) begin
            @(negedge clk);
            chk("lock_addr", oreq.a.addr, 32'h2000_0010);
            chk("lock_req", oreq.req, 1);
            step();
            rsp.rvalid = 0;
        end
        rsp.gnt = 1;
        step();
        step();
        setreq(0, 0, 0);
        rsp.gnt = 0;
        step();
        chk("lock_len", glog.size(), 3);
        chk("lock_g1", glog.size() > 1 ? glog[1] : 99, 1);
        chk("lock_g2", glog.size() > 2 ? glog[2] : 99, 0);

        // FIFO full: no bypass on the popping cycle
        do_reset();
        setreq(1, 0, 0);
        rsp.gnt = 1;
        repeat (4) step();
        @(negedge clk);
        chk("full_outstanding", outst, 4);
        chk("full_req", oreq.req, 0);
        step();
        rsp.rvalid = 1;
        @(negedge clk);
        chk("full_pop_port0", mrsp[0].rvalid, 1);
        chk("full_pop_req", oreq.req, 0);
        step();
        rsp.rvalid = 0;
        @(negedge clk);
        chk("full_after_req", oreq.req, 1);
        chk("full_after_outstanding", outst, 3);
        step();

        // Responses routed to different ports in grant order
        do_reset();
        setreq(0, 0, 1);
        rsp.gnt = 1;
        step();
        setreq(1, 0, 0);
        step();
        setreq(0, 0, 0);
        rsp.gnt = 0;
        @(negedge clk);
        chk("route_outstanding2", outst, 2);
        step();
        rsp.rvalid = 1;
        rsp.r.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("route_rv2", mrsp[2].rvalid, 1);
        chk("route_rv0_idle", mrsp[0].rvalid, 0);
        chk("route_data2", mrsp[2].r.rdata, 32'hDEAD_BEEF);
        step();
        rsp.r.rdata = 32'h1234_5678;
        @(negedge clk);
        chk("route_rv0", mrsp[0].rvalid, 1);
        chk("route_data0", mrsp[0].r.rdata, 32'h1234_5678);
        chk("route_outstanding1", outst, 1);
        step();
        rsp.rvalid = 0;
        @(negedge clk);
        chk("route_outstanding0", outst, 0);
        step();

        // Unexpected response after reset
        do_reset();
        rsp.rvalid = 1;
        @(negedge clk);
        chk("unexp_no_rvalid", {mrsp[2].rvalid, mrsp[1].rvalid, mrsp[0].rvalid}, 0);
        step();
        rsp.rvalid = 0;
        @(negedge clk);
        chk("unexp_err_set", err, 1);
        repeat (3) step();
        @(negedge clk);
        chk("unexp_err_held", err, 1);
        step();

        // Reset with 3 outstanding and a lock held
        do_reset();
        setreq(1, 0, 0);
        rsp.gnt = 1;
        repeat (3) step();
        rsp.gnt = 0;
        setreq(1, 1, 0);
        step();
        rst = 1;
        @(negedge clk);
        chk("midrst_outstanding", outst, 0);
        chk("midrst_req", oreq.req, 0);
        step();
        rst = 0;
        rsp.gnt = 1;
        @(negedge clk);
        chk("midrst_restart_mgr0", mrsp[0].gnt, 1);
        step();

        // Randomized traffic, including withdrawals and occasional reset
        do_reset();
        repeat (1500) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(3) == 0) mreq[i].req = ~mreq[i].req;
                mreq[i].a.addr = $urandom;
                mreq[i].a.wdata = $urandom;
            end
            rsp.gnt = 1'($urandom_range(1));
            rsp.rvalid = $urandom_range(2) == 0;
            rsp.r.rdata = $urandom;
            rst = $urandom_range(199) == 0;
            step();
        end
        rst = 0;
        setreq(0, 0, 0);
        rsp = '0;
        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
